// File: rtl/pwm_multi.sv
// Multi-channel double-buffered PWM generator sharing one prescaled period counter.
// Define PWM_MULTI_CENTER_ALIGN_EN for an up/down (center-aligned) counter.
module pwm_multi #(
  parameter int N  = 8,
  parameter int C  = 4,
  parameter int P  = 16,
  parameter int CW = (C > 1) ? $clog2(C) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [P-1:0]  prescale,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_ch,
  input  logic [N-1:0]  wr_duty,
  output logic [C-1:0]  out,
  output logic          period_start
);

  localparam logic [N-1:0] MAX_CNT = '1;
  localparam logic [N-1:0] ONE     = N'(1);
  localparam logic [N-1:0] MAX_M1  = MAX_CNT - ONE;
  localparam logic [CW:0]  NUM_CH  = (CW+1)'(C);

  logic [P-1:0] r_pcnt;
  logic [N-1:0] r_cnt;
  logic [N-1:0] r_shadow [C];
  logic [N-1:0] r_active [C];
  logic [C-1:0] r_pending;
  logic [C-1:0] r_out;
  logic         r_period_start;

  logic         w_tick;
  logic         w_bound;
  logic         w_wr_ok;

  // Write port: wr_en is a one-cycle valid with no ready; every strobe to an
  // existing channel is accepted, strobes to wr_ch >= C are dropped.
  assign w_wr_ok = wr_en && ({1'b0, wr_ch} < NUM_CH);

  // A pcnt above a freshly lowered prescale simply runs on and wraps.
  assign w_tick = (r_pcnt == prescale);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

`ifdef PWM_MULTI_CENTER_ALIGN_EN
  logic r_dir;  // 1 while counting down

  assign w_bound = w_tick && r_dir && (r_cnt == ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_dir <= 1'b0;
    end else if (w_tick) begin
      if (!r_dir) begin
        r_cnt <= r_cnt + ONE;
        if (r_cnt == MAX_M1) r_dir <= 1'b1;
      end else begin
        r_cnt <= r_cnt - ONE;
        if (r_cnt == ONE) r_dir <= 1'b0;
      end
    end
  end
`else
  assign w_bound = w_tick && (r_cnt == MAX_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= r_cnt + ONE;
    end
  end
`endif

  // The write follows the boundary load so a coincident write stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending      <= '0;
      r_out          <= '0;
      r_period_start <= 1'b0;
      for (int c = 0; c < C; c++) begin
        r_shadow[c] <= '0;
        r_active[c] <= '0;
      end
    end else begin
      r_period_start <= w_bound;
      for (int c = 0; c < C; c++) begin
        if (w_bound && r_pending[c]) begin
          r_active[c]  <= r_shadow[c];
          r_pending[c] <= 1'b0;
        end
        if (w_wr_ok && (int'(wr_ch) == c)) begin
          r_shadow[c]  <= wr_duty;
          r_pending[c] <= 1'b1;
        end
        if (!ena) begin
          r_out[c] <= 1'b0;
        end else if (r_active[c] == MAX_CNT) begin
          r_out[c] <= 1'b1;
        end else begin
          r_out[c] <= (r_cnt < r_active[c]);
        end
      end
    end
  end

  assign out          = r_out;
  assign period_start = r_period_start;

endmodule
